// File: rtl/nios2_mul_unit.sv
// nios2_mul_unit
// Two-stage pipelined W x W integer multiplier for the Nios II execute/memory path.
// Stage 1 registers four half-width partial products and a signed-correction term.
// Stage 2 sums them into the full 2W-bit unsigned product, applies the correction
// for signed high-word ops, and registers the selected word.
//
// Ports:
//   clk           clock, rising edge active
//   reset_n       asynchronous active-low reset, clears every pipeline register
//   E_src1/E_src2 operands A/B (W bits)
//   E_op          00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   E_valid       operands/op valid this cycle
//   M_en          pipeline advance enable; 0 freezes all pipeline registers
//   flush         synchronous kill of all in-flight valids (wins over M_en)
//   M_mul_result  registered result leaving stage 2
//   M_mul_valid   M_mul_result is valid
module nios2_mul_unit #(
   parameter int unsigned W = 32  // must be even and >= 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] E_src1,
   input  logic [W-1:0] E_src2,
   input  logic [1:0]   E_op,
   input  logic         E_valid,
   input  logic         M_en,
   input  logic         flush,
   output logic [W-1:0] M_mul_result,
   output logic         M_mul_valid
);

   localparam int unsigned H = W / 2;

   typedef enum logic [1:0] {
      OpMul    = 2'b00,
      OpMulxuu = 2'b01,
      OpMulxsu = 2'b10,
      OpMulxss = 2'b11
   } mul_op_e;

   // Stage 1 state
   logic [W-1:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
   logic [W-1:0] corr_q;
   mul_op_e      op_q;
   logic         v1_q;

   // Stage 2 state
   logic [W-1:0] result_q;
   logic         valid_q;

   // Stage 1 next-state
   logic [H-1:0] a_lo, a_hi, b_lo, b_hi;
   logic [W-1:0] pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;
   logic [W-1:0] corr_d;
   logic         sa, sb;

   always_comb begin
      a_lo = E_src1[H-1:0];
      a_hi = E_src1[W-1:H];
      b_lo = E_src2[H-1:0];
      b_hi = E_src2[W-1:H];
      // H x H products always fit in W bits, so zero-extended operands suffice.
      pp_ll_d = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_lo};
      pp_lh_d = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_hi};
      pp_hl_d = {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_lo};
      pp_hh_d = {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_hi};
      sa = E_op[1];
      sb = (mul_op_e'(E_op) == OpMulxss);
      // A negative signed operand contributes -(other << W) to the signed product;
      // only its effect on the high word is kept here and subtracted in stage 2.
      corr_d = ((sa && E_src1[W-1]) ? E_src2 : '0) + ((sb && E_src2[W-1]) ? E_src1 : '0);
   end

   // Stage 2 next-state
   logic [W:0]     mid;
   logic [2*W-1:0] full;
   logic [W-1:0]   hi;
   logic [W-1:0]   result_d;

   always_comb begin
      mid = {1'b0, pp_lh_q} + {1'b0, pp_hl_q};
      // The unsigned product is < 2^(2W), so a carry into bit 2W can never occur and
      // a 2W-bit sum is exact.
      full = {{W{1'b0}}, pp_ll_q}
           + ({{(W-1){1'b0}}, mid} << H)
           + {pp_hh_q, {W{1'b0}}};
      hi       = full[2*W-1:W] - corr_q;
      result_d = (op_q == OpMul) ? full[W-1:0] : hi;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pp_ll_q  <= '0;
         pp_lh_q  <= '0;
         pp_hl_q  <= '0;
         pp_hh_q  <= '0;
         corr_q   <= '0;
         op_q     <= OpMul;
         v1_q     <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         // Data registers load on every enabled edge, valid or not.
         if (M_en) begin
            pp_ll_q  <= pp_ll_d;
            pp_lh_q  <= pp_lh_d;
            pp_hl_q  <= pp_hl_d;
            pp_hh_q  <= pp_hh_d;
            corr_q   <= corr_d;
            op_q     <= mul_op_e'(E_op);
            result_q <= result_d;
         end
         if (flush) begin
            v1_q    <= 1'b0;
            valid_q <= 1'b0;
         end else if (M_en) begin
            v1_q    <= E_valid;
            valid_q <= v1_q;
         end
      end
   end

   assign M_mul_result = result_q;
   assign M_mul_valid  = valid_q;

endmodule

// File: tb/tb_nios2_mul_unit.sv
// Self-checking bench for nios2_mul_unit: a W=32 and a W=8 instance share all
// controls (the W=8 one sees the low operand bytes); a reference pipeline built on
// plain sign/zero-extended multiplication is compared against both every cycle.
module tb_nios2_mul_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] E_src1 = '0, E_src2 = '0;
   logic [1:0]  E_op = '0;
   logic        E_valid = 1'b0, M_en = 1'b0, flush = 1'b0;
   logic [31:0] res32;
   logic        vld32;
   logic [7:0]  res8;
   logic        vld8;

   int n_vec  = 0;
   int n_fail = 0;
   bit chk    = 1'b0;

   always #5 clk = ~clk;

   nios2_mul_unit #(.W(32)) dut32 (
      .clk(clk), .reset_n(reset_n), .E_src1(E_src1), .E_src2(E_src2), .E_op(E_op),
      .E_valid(E_valid), .M_en(M_en), .flush(flush),
      .M_mul_result(res32), .M_mul_valid(vld32)
   );

   nios2_mul_unit #(.W(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .E_src1(E_src1[7:0]), .E_src2(E_src2[7:0]),
      .E_op(E_op), .E_valid(E_valid), .M_en(M_en), .flush(flush),
      .M_mul_result(res8), .M_mul_valid(vld8)
   );

   // Reference: extend operands per op signedness, multiply at 2W bits, pick a word.
   function automatic logic [31:0] ref32(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] ax, bx, p;
      ax = op[1] ? {{32{a[31]}}, a} : {32'b0, a};
      bx = (op == 2'b11) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ax * bx;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [7:0] ref8(input logic [1:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
      logic [15:0] ax, bx, p;
      ax = op[1] ? {{8{a[7]}}, a} : {8'b0, a};
      bx = (op == 2'b11) ? {{8{b[7]}}, b} : {8'b0, b};
      p  = ax * bx;
      return (op == 2'b00) ? p[7:0] : p[15:8];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Reference pipeline: slot 1 holds the result of what was sampled, slot 2 is visible.
   bit          m1_v = 0, m2_v = 0;
   logic [31:0] m1_r32 = '0, m2_r32 = '0;
   logic [7:0]  m1_r8 = '0, m2_r8 = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m1_v <= 0; m2_v <= 0;
         m1_r32 <= '0; m2_r32 <= '0; m1_r8 <= '0; m2_r8 <= '0;
      end else begin
         if (M_en) begin
            m1_r32 <= ref32(E_op, E_src1, E_src2);
            m1_r8  <= ref8(E_op, E_src1[7:0], E_src2[7:0]);
            m2_r32 <= m1_r32;
            m2_r8  <= m1_r8;
         end
         if (flush) begin
            m1_v <= 0; m2_v <= 0;
         end else if (M_en) begin
            m1_v <= E_valid; m2_v <= m1_v;
         end
      end
   end

   always @(negedge clk) begin
      if (chk) begin
         check("valid32", {63'b0, vld32}, {63'b0, m2_v});
         check("result32", {32'b0, res32}, {32'b0, m2_r32});
         check("valid8", {63'b0, vld8}, {63'b0, m2_v});
         check("result8", {56'b0, res8}, {56'b0, m2_r8});
      end
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic v, input logic en, input logic fl);
      @(negedge clk);
      E_op = op; E_src1 = a; E_src2 = b; E_valid = v; M_en = en; flush = fl;
   endtask

   task automatic idle();
      issue(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
   endtask

   // Literal check of the 32-bit output just after the coming edge.
   task automatic lit(input string name, input logic [31:0] exp, input logic v);
      @(posedge clk);
      #1;
      check(name, {32'b0, res32}, {32'b0, exp});
      check({name, "_v"}, {63'b0, vld32}, {63'b0, v});
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h0000_0080;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      // Pin the reference itself.
      check("pin_mul", {32'b0, ref32(2'b00, 32'h00012345, 32'h10)}, 64'h00123450);
      check("pin_xuu", {32'b0, ref32(2'b01, '1, '1)}, 64'hFFFFFFFE);
      check("pin_xss", {32'b0, ref32(2'b11, '1, '1)}, 64'h0);
      check("pin_xsu", {32'b0, ref32(2'b10, '1, '1)}, 64'hFFFFFFFF);
      check("pin_xss_min", {32'b0, ref32(2'b11, 32'h80000000, 32'h80000000)}, 64'h40000000);
      check("pin8_xss_min", {56'b0, ref8(2'b11, 8'h80, 8'h80)}, 64'h40);
      check("pin8_xuu", {56'b0, ref8(2'b01, 8'hFF, 8'hFF)}, 64'hFE);

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset_result", {32'b0, res32}, 64'h0);
      check("reset_valid", {63'b0, vld32}, 64'h0);
      reset_n = 1'b1;
      chk = 1'b1;

      // Basic MUL, valid for exactly one cycle.
      issue(2'b00, 32'h00012345, 32'h00000010, 1, 1, 0);
      idle();
      lit("mul_basic", 32'h00123450, 1'b1);
      idle();
      lit("mul_basic_once", 32'h0, 1'b0);

      // Back-to-back stream of four ops.
      issue(2'b01, '1, '1, 1, 1, 0);
      issue(2'b11, '1, '1, 1, 1, 0);
      lit("b2b_xuu", 32'hFFFFFFFE, 1'b1);
      issue(2'b10, '1, '1, 1, 1, 0);
      lit("b2b_xss", 32'h00000000, 1'b1);
      issue(2'b11, 32'h80000000, 32'h80000000, 1, 1, 0);
      lit("b2b_xsu", 32'hFFFFFFFF, 1'b1);
      idle();
      lit("b2b_xss_min", 32'h40000000, 1'b1);
      idle();
      idle();

      // Mid-flight stall of three cycles.
      issue(2'b00, 32'd7, 32'd6, 1, 1, 0);
      repeat (3) issue(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();
      lit("stall_42", 32'd42, 1'b1);
      idle();

      // Flush with M_en=1, E_valid=1 on the flush edge is discarded.
      issue(2'b01, '1, '1, 1, 1, 0);
      issue(2'b11, '1, '1, 1, 1, 0);
      issue(2'b00, 32'd3, 32'd3, 1, 1, 1);
      #1;
      @(posedge clk);
      #1;
      check("flush_en_v", {63'b0, vld32}, 64'h0);
      idle();
      @(posedge clk);
      #1;
      check("flush_en_none", {63'b0, vld32}, 64'h0);
      idle();

      // Flush with M_en=0.
      issue(2'b00, 32'd5, 32'd5, 1, 1, 0);
      issue(2'b00, 32'd9, 32'd9, 1, 1, 0);
      issue(2'b00, 32'd0, 32'd0, 0, 0, 1);
      @(posedge clk);
      #1;
      check("flush_stall_v", {63'b0, vld32}, 64'h0);
      idle();
      @(posedge clk);
      #1;
      check("flush_stall_none", {63'b0, vld32}, 64'h0);
      idle();

      // Asynchronous reset while an op sits in stage 2.
      issue(2'b00, 32'h0000FFFF, 32'h0000FFFF, 1, 1, 0);
      idle();
      @(posedge clk);
      #2;
      check("pre_reset_v", {63'b0, vld32}, 64'h1);
      check("pre_reset_r", {32'b0, res32}, 64'hFFFE0001);
      reset_n = 1'b0;
      #1;
      check("async_reset_r", {32'b0, res32}, 64'h0);
      check("async_reset_v", {63'b0, vld32}, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      idle();
      idle();

      // Random operands per op, random stalls/flushes.
      for (int op = 0; op < 4; op++) begin
         for (int i = 0; i < 10000; i++) begin
            issue(op[1:0], pick(), pick(), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 31) == 0));
         end
      end
      idle();
      idle();
      idle();
      @(negedge clk);
      chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
